cp0_exc_unit: RTL and testbench
===============================

// Module: cp0_exc_unit
// PURPOSE
//  Coprocessor-0 for the multi-cycle MIPS core. Holds SR, Cause, EPC and PrID.
//  Synchronises the six hardware interrupt lines and raises irq to the controller FSM.
//  Consumes the controller's cp0Wr, EXLSet and EXLClr strobes.
//  Supplies EPC to the NPC mux for eret and read data for mfc0.
// PARAMETERS
//  PRID      32'h0000_4D49  value returned when reading PrID (reg 15)
//  SYNC_EN   1              1: two-flop synchroniser on hwint; 0: hwint sampled by a single flop
// PORTS
//  clk      in   1      clock, all state updates on rising edge
//  rst      in   1      synchronous reset, active-high
//  sel      in   5      CP0 register index (instr rd field) for mfc0/mtc0
//  din      in   32     mtc0 write data (GPR[rt])
//  we       in   1      cp0Wr from controller: write din to reg[sel]
//  pc       in   32:2   word PC presented during the controller's interrupt state (return address)
//  hwint    in   6      external interrupt request levels (Timer0, Timer1, devices)
//  exl_set  in   1      EXLSet: interrupt taken this cycle
//  exl_clr  in   1      EXLClr: eret executing
//  irq      out  1      interrupt request to controller
//  epc      out  32:2   current EPC, feeds NPC for eret
//  dout     out  32     mfc0 read data
// BEHAVIOUR
//  Register map:
//   SR(12): IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
//   Cause(13): IP=[15:10] read-only; all other bits read 0.
//   EPC(14): {epc,2'b00}.
//   PrID(15): PRID.
//   Any other sel reads 32'h0.
//  Reset (rst=1 at edge):
//   IM=0, EXL=0, IE=0, IP=0, epc=0, sync flops=0.
//   Hence irq=0 and dout=0 for sel 12/13/14 the cycle after reset.
//  hwint path:
//   sync1<=hwint; sync2<=sync1; IP<=sync2 (SYNC_EN=1).
//   Total 3 edges from a hwint change to an IP change.
//   IP is level-following, not sticky. The device holds its line until serviced.
//  irq:
//   Combinational: irq = |(IP & IM) & IE & ~EXL.
//   Must be stable throughout the controller's interrupt state.
//  mtc0 (we=1):
//   sel=12 loads IM, EXL, IE from din.
//   sel=14 loads epc<=din[31:2].
//   sel=13, 15 and others: ignored, no state change.
//  exl_set:
//   EXL<=1 and epc<=pc on the same edge.
//   Overrides a simultaneous mtc0 to SR.EXL or to EPC.
//  exl_clr:
//   EXL<=0.
//   If exl_set and exl_clr are both high, exl_set wins (EXL=1).
//  dout:
//   Combinational mux on sel.
//   Reads pre-edge values: a read in the same cycle as a write returns the old value.
//  epc output: reflects the register directly, with no bypass of a same-cycle write.
//  rst overrides all strobes. A reset during an interrupt sequence clears EXL and EPC.
// TESTING
//  1. Reset: after rst, sel=12/13/14 -> dout=0, irq=0; sel=15 -> dout=PRID.
//  2. mtc0 SR: din=32'h0000_FC01, we=1, sel=12
//     -> SR reads 32'h0000_FC01.
//     Then hwint=6'b000001 -> irq=1 exactly 3 cycles later; Cause reads 32'h0000_0400.
//  3. Take interrupt: pc=30'h0000_0C05, exl_set=1
//     -> epc=30'h0000_0C05, SR.EXL=1, irq=0 next cycle.
//     Then exl_clr=1 -> EXL=0, irq=1 again while hwint is held.
//  4. Precedence: exl_set=1 with we=1, sel=14, din=32'h1234_5678 -> epc=pc, not din.
//     exl_set=1 with exl_clr=1 -> EXL=1.
//  5. Masking: IM=6'b000010, hwint=6'b000001 -> irq stays 0.
//     IE=0 with matching IM -> irq 0.
//     Writes to sel=13 or sel=15 leave Cause and PrID unchanged.
//  6. Mid-sequence reset: EXL=1, epc nonzero, then rst=1 for one cycle -> EXL=0, epc=0, irq=0.

Source files
------------

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 for the multi-cycle MIPS core: SR, Cause, EPC and PrID,
// hardware interrupt synchronisation, and the irq request to the controller.
module cp0_exc_unit #(
  parameter logic [31:0] PRID    = 32'h0000_4D49,
  parameter bit          SYNC_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  sel,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [31:2] pc,
  input  logic [5:0]  hwint,
  input  logic        exl_set,
  input  logic        exl_clr,
  output logic        irq,
  output logic [31:2] epc,
  output logic [31:0] dout
);

  localparam int unsigned NINT  = 6;
  localparam int unsigned SELW  = 5;
  localparam logic [SELW-1:0] SEL_SR    = SELW'(12);
  localparam logic [SELW-1:0] SEL_CAUSE = SELW'(13);
  localparam logic [SELW-1:0] SEL_EPC   = SELW'(14);
  localparam logic [SELW-1:0] SEL_PRID  = SELW'(15);

  logic [NINT-1:0] im;
  logic [NINT-1:0] ip;
  logic [NINT-1:0] ip_in;
  logic            exl;
  logic            ie;

  // Bring the asynchronous interrupt levels into the clock domain
  if (SYNC_EN) begin : g_sync2
    logic [NINT-1:0] sync1;
    logic [NINT-1:0] sync2;

    // Two-flop synchroniser
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1 <= '0;
        sync2 <= '0;
      end else begin
        sync1 <= hwint;
        sync2 <= sync1;
      end
    end

    assign ip_in = sync2;
  end else begin : g_sync1
    logic [NINT-1:0] sync1;

    // Single sampling flop
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1 <= '0;
      end else begin
        sync1 <= hwint;
      end
    end

    assign ip_in = sync1;
  end

  // Cause.IP follows the synchronised levels; it is not sticky
  always_ff @(posedge clk) begin
    if (rst) begin
      ip <= '0;
    end else begin
      ip <= ip_in;
    end
  end

  // SR fields: mtc0 loads them, the exception strobes then override EXL
  always_ff @(posedge clk) begin
    if (rst) begin
      im  <= '0;
      ie  <= 1'b0;
      exl <= 1'b0;
    end else begin
      if (we && sel == SEL_SR) begin
        im  <= din[15:10];
        exl <= din[1];
        ie  <= din[0];
      end
      if (exl_set) begin
        exl <= 1'b1;
      end else if (exl_clr) begin
        exl <= 1'b0;
      end
    end
  end

  // EPC: interrupt entry captures the PC and beats a same-cycle mtc0
  always_ff @(posedge clk) begin
    if (rst) begin
      epc <= '0;
    end else if (exl_set) begin
      epc <= pc;
    end else if (we && sel == SEL_EPC) begin
      epc <= din[31:2];
    end
  end

  // Interrupt request: any enabled pending line while not already in an exception
  always_comb begin
    irq = (|(ip & im)) & ie & ~exl;
  end

  // mfc0 read mux on the pre-edge register values
  always_comb begin
    dout = 32'h0;
    case (sel)
      SEL_SR:    dout = {16'h0, im, 8'h0, exl, ie};
      SEL_CAUSE: dout = {16'h0, ip, 10'h0};
      SEL_EPC:   dout = {epc, 2'b00};
      SEL_PRID:  dout = PRID;
      default:   dout = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed and randomized checks of cp0_exc_unit against a behavioural model.
module tb_cp0_exc_unit;

  localparam logic [31:0] PRID = 32'h0000_4D49;

  logic        clk;
  logic        rst;
  logic [4:0]  sel;
  logic [31:0] din;
  logic        we;
  logic [31:2] pc;
  logic [5:0]  hwint;
  logic        exl_set;
  logic        exl_clr;
  logic        irq;
  logic [31:2] epc;
  logic [31:0] dout;

  int vectors;
  int miscompares;

  // Reference model state
  logic [5:0]  m_im;
  logic [5:0]  m_ip;
  logic        m_ie;
  logic        m_exl;
  logic [31:2] m_epc;
  logic [5:0]  m_pipe[$];

  cp0_exc_unit #(.PRID(PRID), .SYNC_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .sel(sel), .din(din), .we(we), .pc(pc),
    .hwint(hwint), .exl_set(exl_set), .exl_clr(exl_clr),
    .irq(irq), .epc(epc), .dout(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_irq();
    return (((m_ip & m_im) != 6'b0) && m_ie && !m_exl);
  endfunction

  function automatic logic [31:0] m_dout(input logic [4:0] s);
    logic [31:0] r;
    r = 32'h0;
    if (s == 5'd12) begin
      r[15:10] = m_im;
      r[1] = m_exl;
      r[0] = m_ie;
    end else if (s == 5'd13) begin
      r[15:10] = m_ip;
    end else if (s == 5'd14) begin
      r = {m_epc, 2'b00};
    end else if (s == 5'd15) begin
      r = PRID;
    end
    return r;
  endfunction

  // Model of one rising edge; hwint reaches IP through a 3-edge delay line
  task automatic model_edge();
    logic [5:0] oldest;
    if (rst) begin
      m_im = '0; m_ie = 1'b0; m_exl = 1'b0; m_epc = '0; m_ip = '0;
      m_pipe = '{6'b0, 6'b0};
    end else begin
      m_pipe.push_back(hwint);
      oldest = m_pipe.pop_front();
      if (we && sel == 5'd12) begin
        m_im = din[15:10]; m_exl = din[1]; m_ie = din[0];
      end
      if (we && sel == 5'd14) m_epc = din[31:2];
      if (exl_clr) m_exl = 1'b0;
      if (exl_set) begin
        m_exl = 1'b1;
        m_epc = pc;
      end
      m_ip = oldest;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the model, then compare all outputs
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("irq", {31'b0, irq}, {31'b0, m_irq()});
    check("epc", {epc, 2'b00}, {m_epc, 2'b00});
    check("dout", dout, m_dout(sel));
  endtask

  task automatic idle();
    we = 1'b0; exl_set = 1'b0; exl_clr = 1'b0; rst = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    m_im = '0; m_ip = '0; m_ie = 1'b0; m_exl = 1'b0; m_epc = '0;
    m_pipe = '{6'b0, 6'b0};
    rst = 1'b1; sel = 5'd12; din = '0; we = 1'b0; pc = '0;
    hwint = '0; exl_set = 1'b0; exl_clr = 1'b0;

    // 1. Reset state
    step();
    step();
    idle();
    sel = 5'd12; step(); check("rst_sr", dout, 32'h0); check("rst_irq", {31'b0, irq}, 32'h0);
    sel = 5'd13; step(); check("rst_cause", dout, 32'h0);
    sel = 5'd14; step(); check("rst_epc", dout, 32'h0);
    sel = 5'd15; step(); check("rst_prid", dout, PRID);

    // 2. mtc0 SR, then interrupt latency
    sel = 5'd12; din = 32'h0000_FC01; we = 1'b1; step();
    check("sr_write", dout, 32'h0000_FC01);
    we = 1'b0; hwint = 6'b000001;
    step(); check("lat1", {31'b0, irq}, 32'h0);
    step(); check("lat2", {31'b0, irq}, 32'h0);
    step(); check("lat3", {31'b0, irq}, 32'h1);
    sel = 5'd13; step(); check("cause_ip", dout, 32'h0000_0400);

    // 3. Take interrupt and return
    sel = 5'd12; pc = 30'h0000_0C05; exl_set = 1'b1; step();
    check("take_epc", {epc, 2'b00}, {30'h0000_0C05, 2'b00});
    check("take_sr", dout, 32'h0000_FC03);
    check("take_irq", {31'b0, irq}, 32'h0);
    exl_set = 1'b0; exl_clr = 1'b1; step();
    check("eret_irq", {31'b0, irq}, 32'h1);
    exl_clr = 1'b0;

    // 4. Precedence
    pc = 30'h0000_0ABC; exl_set = 1'b1; we = 1'b1; sel = 5'd14; din = 32'h1234_5678; step();
    check("prec_epc", {epc, 2'b00}, {30'h0000_0ABC, 2'b00});
    we = 1'b0; exl_set = 1'b1; exl_clr = 1'b1; sel = 5'd12; step();
    check("prec_exl", {31'b0, dout[1]}, 32'h1);
    idle();

    // 5. Masking and read-only registers
    sel = 5'd12; din = 32'h0000_0801; we = 1'b1; step();
    we = 1'b0; step(); check("mask_im", {31'b0, irq}, 32'h0);
    din = 32'h0000_0400; we = 1'b1; step();
    we = 1'b0; step(); check("mask_ie", {31'b0, irq}, 32'h0);
    sel = 5'd13; din = 32'hFFFF_FFFF; we = 1'b1; step();
    we = 1'b0; step(); check("cause_ro", dout, 32'h0000_0400);
    sel = 5'd15; we = 1'b1; step();
    we = 1'b0; step(); check("prid_ro", dout, PRID);

    // 6. Mid-sequence reset
    sel = 5'd12; din = 32'h0000_FC01; we = 1'b1; step();
    we = 1'b0; pc = 30'h0000_0777; exl_set = 1'b1; step();
    exl_set = 1'b0; rst = 1'b1; step();
    rst = 1'b0; step();
    check("mid_rst_sr", dout, 32'h0);
    check("mid_rst_epc", {epc, 2'b00}, 32'h0);
    check("mid_rst_irq", {31'b0, irq}, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      we      = ($urandom_range(0, 3) == 0);
      exl_set = ($urandom_range(0, 9) == 0);
      exl_clr = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0: sel = 5'd12;
        1: sel = 5'd13;
        2: sel = 5'd14;
        3: sel = 5'd15;
        default: sel = 5'($urandom);
      endcase
      if (we && sel == 5'd12) exl_clr = 1'b0;
      din = $urandom;
      if (sel == 5'd12 && $urandom_range(0, 1) == 1) din[0] = 1'b1;
      pc = 30'($urandom);
      if ($urandom_range(0, 4) == 0) hwint = 6'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
